// File: rtl/dvp_camera_pkg.sv
// Shared timing defaults, RGB565 bar colours and frame-geometry helpers for the
// DVP camera model.
package dvp_camera_pkg;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic int lineLen(int hActive, int hBlank);
    return 2 * hActive + hBlank;
  endfunction

  function automatic int frameLines(int vsyncLines, int vBack, int vActive, int vFront);
    return vsyncLines + vBack + vActive + vFront;
  endfunction

  function automatic logic [15:0] barColor(logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_camera_pattern.sv
// Combinational (x, y) -> RGB565 pixel generator. Defining SIM_CAMERA_COLORBAR_EN
// selects an 8-bar colour pattern; otherwise a {y, x} counting pattern is produced.
module dvp_camera_pattern
  import dvp_camera_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic [15:0] pixel_o
);

`ifdef SIM_CAMERA_COLORBAR_EN
  localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

  logic [15:0] barIdx;
  logic        unusedBits;

  // Positions past the last bar only occur outside the active window.
  always_comb begin
    barIdx  = x_i / BAR_W;
    pixel_o = (barIdx > 16'd7) ? RGB_BLACK : barColor(barIdx[2:0]);
  end

  assign unusedBits = ^y_i;
`else
  logic unusedBits;

  assign pixel_o    = {y_i[7:0], x_i[7:0]};
  assign unusedBits = ^{x_i[15:8], y_i[15:8], 16'(H_ACTIVE)};
`endif

endmodule

// File: rtl/dvp_camera_model.sv
// Behavioural OV5642-style DVP source: pclk = xclk/2, outputs update on pclk
// falling edges. Pixel pattern chosen by SIM_CAMERA_COLORBAR_EN (see pattern block).
module dvp_camera_model
  import dvp_camera_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic       xclk,
  input  logic       rst,
  output logic       pclk,
  output logic       href,
  output logic       vsync,
  output logic [7:0] data
);

  localparam int LINE_LEN    = lineLen(H_ACTIVE, H_BLANK);
  localparam int FRAME_LINES = frameLines(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int V_START     = VSYNC_LINES + V_BACK;

  localparam logic [15:0] H_LAST   = 16'(LINE_LEN - 1);
  localparam logic [15:0] V_LAST   = 16'(FRAME_LINES - 1);
  localparam logic [15:0] H_BYTES  = 16'(2 * H_ACTIVE);
  localparam logic [15:0] V_SYNC_N = 16'(VSYNC_LINES);
  localparam logic [15:0] V_BEGIN  = 16'(V_START);
  localparam logic [15:0] V_END    = 16'(V_START + V_ACTIVE);

  logic        phase_q;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] xPos, yPos, pixel;

  assign xPos = {1'b0, hcnt_q[15:1]};
  assign yPos = vcnt_q - V_BEGIN;

  dvp_camera_pattern #(
    .H_ACTIVE(H_ACTIVE)
  ) uPattern (
    .x_i    (xPos),
    .y_i    (yPos),
    .pixel_o(pixel)
  );

  // Decode the current position and compute the wrapped counter successors.
  always_comb begin
    hcnt_d = hcnt_q + 16'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 16'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 16'd0 : vcnt_q + 16'd1;
    end
    vsync_d = (vcnt_q < V_SYNC_N);
    href_d  = (vcnt_q >= V_BEGIN) && (vcnt_q < V_END) && (hcnt_q < H_BYTES);
    data_d  = 8'h00;
    if (href_d) begin
      data_d = hcnt_q[0] ? pixel[7:0] : pixel[15:8];
    end
  end

  // phase_q high means this edge is the pclk falling edge, where everything advances.
  always_ff @(posedge xclk) begin
    if (rst) begin
      phase_q <= 1'b0;
      hcnt_q  <= 16'd0;
      vcnt_q  <= 16'd0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= ~phase_q;
      if (phase_q) begin
        hcnt_q  <= hcnt_d;
        vcnt_q  <= vcnt_d;
        href_q  <= href_d;
        vsync_q <= vsync_d;
        data_q  <= data_d;
      end
    end
  end

  assign pclk  = phase_q;
  assign href  = href_q;
  assign vsync = vsync_q;
  assign data  = data_q;

endmodule

// File: tb/tb_dvp_camera_model.sv
// Self-checking bench for dvp_camera_model using a shrunken frame geometry
// (line = 36 pclk, frame = 15 lines, active window starts on line 5).
module tb_dvp_camera_model;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int LINE = 2 * HA + HB;
  localparam int FRAME = VS + VB + VA + VF;
  localparam int VSTART = VS + VB;

  logic       xclk;
  logic       rst;
  logic       pclk;
  logic       href;
  logic       vsync;
  logic [7:0] data;

  int nVec;
  int nMiss;
  int edgeCount;

  typedef struct {
    int         h;
    int         v;
    int         frame;
    logic       expHref;
    logic       expVsync;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[16];

  dvp_camera_model #(
    .H_ACTIVE   (HA),
    .H_BLANK    (HB),
    .V_ACTIVE   (VA),
    .VSYNC_LINES(VS),
    .V_BACK     (VB),
    .V_FRONT    (VF)
  ) dut (
    .xclk (xclk),
    .rst  (rst),
    .pclk (pclk),
    .href (href),
    .vsync(vsync),
    .data (data)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  // One xclk rising edge, then sample/drive on the following falling edge.
  task automatic applyStimulus();
    @(posedge xclk);
    @(negedge xclk);
    edgeCount++;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int target;
    int t;
    int highCnt;
    int hrefRises;
    int hrefHigh;
    int firstHref;
    int firstWidth;
    int curWidth;
    logic prevV;
    logic prevH;
    logic seen;

    nVec = 0;
    nMiss = 0;
    edgeCount = 0;

    vecs[0]  = '{0,  0,  0, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{35, 2,  0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{0,  3,  0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{0,  5,  0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{3,  5,  0, 1'b1, 1'b0, 8'h01};
    vecs[5]  = '{6,  10, 0, 1'b1, 1'b0, 8'h05};
    vecs[6]  = '{7,  10, 0, 1'b1, 1'b0, 8'h03};
    vecs[7]  = '{30, 10, 0, 1'b1, 1'b0, 8'h05};
    vecs[8]  = '{31, 10, 0, 1'b1, 1'b0, 8'h0F};
    vecs[9]  = '{32, 10, 0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{35, 10, 0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{0,  12, 0, 1'b1, 1'b0, 8'h07};
    vecs[12] = '{3,  12, 0, 1'b1, 1'b0, 8'h01};
    vecs[13] = '{0,  13, 0, 1'b0, 1'b0, 8'h00};
    vecs[14] = '{0,  0,  1, 1'b0, 1'b1, 8'h00};
    vecs[15] = '{7,  10, 1, 1'b1, 1'b0, 8'h03};

    rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("rst_pclk", int'(pclk), 0);
    checkOutput("rst_href", int'(href), 0);
    checkOutput("rst_vsync", int'(vsync), 0);
    checkOutput("rst_data", int'(data), 0);

    rst = 1'b0;
    edgeCount = 0;
    applyStimulus();
    checkOutput("edge1_pclk", int'(pclk), 1);
    checkOutput("edge1_vsync", int'(vsync), 0);
    applyStimulus();
    checkOutput("edge2_pclk", int'(pclk), 0);
    checkOutput("edge2_vsync", int'(vsync), 1);

    for (int i = 0; i < 16; i++) begin
      target = 2 * (vecs[i].frame * FRAME * LINE + vecs[i].v * LINE + vecs[i].h) + 2;
      while (edgeCount < target) applyStimulus();
      checkOutput($sformatf("vec%0d_href", i), int'(href), int'(vecs[i].expHref));
      checkOutput($sformatf("vec%0d_vsync", i), int'(vsync), int'(vecs[i].expVsync));
      checkOutput($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].expData));
    end

    // Find the next VSYNC rising edge, then measure a whole frame from it.
    prevV = vsync;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      applyStimulus();
      if (vsync && !prevV) seen = 1'b1;
      prevV = vsync;
    end
    checkOutput("vsync_rise_found", int'(seen), 1);

    t = 0;
    highCnt = 1;
    hrefRises = 0;
    hrefHigh = 0;
    firstHref = -1;
    firstWidth = 0;
    curWidth = 0;
    prevV = vsync;
    prevH = href;
    seen = 1'b0;
    while (!seen && t < 3000) begin
      applyStimulus();
      t++;
      if (vsync && !prevV) begin
        seen = 1'b0;
        break;
      end
      if (vsync) highCnt++;
      if (href && !prevH) begin
        hrefRises++;
        if (firstHref < 0) firstHref = t;
      end
      if (href) begin
        hrefHigh++;
        curWidth++;
      end
      if (!href && prevH && firstWidth == 0) firstWidth = curWidth;
      prevV = vsync;
      prevH = href;
    end
    checkOutput("vsync_width", highCnt, VS * LINE * 2);
    checkOutput("frame_period", t, 2 * LINE * FRAME);
    checkOutput("href_pulses", hrefRises, VA);
    checkOutput("href_width", firstWidth, 2 * (2 * HA));
    checkOutput("href_total", hrefHigh, VA * 2 * (2 * HA));
    checkOutput("href_first_start", firstHref, 2 * VSTART * LINE);

    // Now at position (0,0) of a fresh frame; run to line 7, hcnt 20.
    repeat (2 * (7 * LINE + 20)) applyStimulus();
    checkOutput("pre_rst_href", int'(href), 1);
    checkOutput("pre_rst_data", int'(data), 8'h02);
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid_rst_pclk", int'(pclk), 0);
    checkOutput("mid_rst_href", int'(href), 0);
    checkOutput("mid_rst_vsync", int'(vsync), 0);
    checkOutput("mid_rst_data", int'(data), 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("restart_edge1_pclk", int'(pclk), 1);
    applyStimulus();
    checkOutput("restart_vsync", int'(vsync), 1);
    highCnt = 1;
    for (int k = 0; k < 1000 && vsync; k++) begin
      applyStimulus();
      if (vsync) highCnt++;
    end
    checkOutput("restart_vsync_width", highCnt, VS * LINE * 2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
